mtm_alu_rx_ctl: RTL and testbench

MTM_ALU_RX_CTL -- requirements
Module: mtm_alu_rx_ctl

---
 rtl/mtm_alu_pkg.sv | 35 +++
 rtl/mtm_alu_rx_ctl_crc4.sv | 21 ++
 rtl/mtm_alu_rx_ctl.sv | 160 ++++++++++++++++
 tb/tb_mtm_alu_rx_ctl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared constants for the MTM ALU serial command receiver.
// Op codes, error flag layout, packet geometry, CRC polynomial.
package mtm_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  localparam int ERR_DATA_BIT = 2;
  localparam int ERR_CRC_BIT  = 1;
  localparam int ERR_OP_BIT   = 0;

  localparam int PKT_LEN    = 11;
  // flag + 8 payload bits; start and stop handled by their own states
  localparam int SHIFT_BITS = PKT_LEN - 2;

  localparam logic [3:0] DATA_PER_FRAME = 4'd8;
  localparam logic [3:0] DCNT_SAT       = 4'd9;

  // x^4 + x + 1
  localparam logic [4:0] CRC_POLY = 5'b10011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK_STOP
  } rx_state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) ||
           (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mtm_alu_rx_ctl_crc4.sv
// Combinational CRC4 (x^4+x+1, init 0) over a 68-bit word, MSB first.
// Ports: data_i [67:0] message, crc_o [3:0] remainder.
module mtm_alu_crc4
  import mtm_alu_pkg::*;
(
  input  logic [67:0] data_i,
  output logic [3:0]  crc_o
);

  always_comb begin
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ data_i[i];
      c  = {c[2:0], 1'b0} ^ (fb ? CRC_POLY[3:0] : 4'b0000);
    end
    crc_o = c;
  end

endmodule

// File: rtl/mtm_alu_rx_ctl.sv
// Serial command receiver: deframes 11-bit packets, assembles operands,
// validates CTL packets and hands commands to the ALU core via valid/ready.
// Ports: clk, rst (sync, active high), sin (serial in, idle high),
// op_valid/op_ready handshake, op_a/op_b [31:0], op_code [2:0],
// err_valid pulse, err_flags [2:0] = {DATA, CRC, OP}.
// Build option: MTM_ALU_CRC_CHECK_EN enables the CTL CRC check.
module mtm_alu_rx_ctl
  import mtm_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [2:0]  op_code,
  output logic        err_valid,
  output logic [2:0]  err_flags
);

  rx_state_t   state_q, state_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic [8:0]  sh_q, sh_d;
  logic [63:0] buf_q, buf_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic        opv_q, opv_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  code_q, code_d;
  logic        errv_q, errv_d;
  logic [2:0]  errf_q, errf_d;

  logic        data_err;
  logic        crc_err;
  logic        op_err;

`ifdef MTM_ALU_CRC_CHECK_EN
  logic [3:0] crc_calc;
  logic       ctl_unused;

  // buf_q is {B, A}; the CTL flag bit is always 1 here
  mtm_alu_crc4 u_crc (
    .data_i ({buf_q, 1'b1, sh_q[6:4]}),
    .crc_o  (crc_calc)
  );

  assign crc_err    = (crc_calc != sh_q[3:0]);
  assign ctl_unused = sh_q[7];
`else
  logic ctl_unused;

  assign crc_err    = 1'b0;
  assign ctl_unused = ^{sh_q[7], sh_q[3:0]};
`endif

  assign data_err = (dcnt_q != DATA_PER_FRAME);
  assign op_err   = !op_legal(sh_q[6:4]);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    buf_d   = buf_q;
    dcnt_d  = dcnt_q;
    opv_d   = opv_q;
    a_d     = a_q;
    b_d     = b_q;
    code_d  = code_q;
    errv_d  = 1'b0;
    errf_d  = 3'b000;

    if (opv_q && op_ready)
      opv_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!sin) begin
          state_d = ST_SHIFT;
          bcnt_d  = '0;
        end
      end
      ST_SHIFT: begin
        sh_d   = {sh_q[7:0], sin};
        bcnt_d = bcnt_q + 4'd1;
        if (bcnt_q == 4'(SHIFT_BITS - 1))
          state_d = ST_CHECK_STOP;
      end
      ST_CHECK_STOP: begin
        state_d = ST_IDLE;
        if (!sin) begin
          errv_d               = 1'b1;
          errf_d[ERR_DATA_BIT] = 1'b1;
          dcnt_d               = '0;
        end else if (!sh_q[8]) begin
          buf_d = {buf_q[55:0], sh_q[7:0]};
          if (dcnt_q != DCNT_SAT)
            dcnt_d = dcnt_q + 4'd1;
        end else begin
          dcnt_d = '0;
          if (data_err || crc_err || op_err) begin
            errv_d = 1'b1;
            if (data_err)
              errf_d[ERR_DATA_BIT] = 1'b1;
            else if (crc_err)
              errf_d[ERR_CRC_BIT] = 1'b1;
            else
              errf_d[ERR_OP_BIT] = 1'b1;
          end else if (opv_q && !op_ready) begin
            // previous command still held: drop this one
            errv_d               = 1'b1;
            errf_d[ERR_DATA_BIT] = 1'b1;
          end else begin
            opv_d  = 1'b1;
            b_d    = buf_q[63:32];
            a_d    = buf_q[31:0];
            code_d = sh_q[6:4];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      sh_q    <= '0;
      buf_q   <= '0;
      dcnt_q  <= '0;
      opv_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      code_q  <= '0;
      errv_q  <= 1'b0;
      errf_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      buf_q   <= buf_d;
      dcnt_q  <= dcnt_d;
      opv_q   <= opv_d;
      a_q     <= a_d;
      b_q     <= b_d;
      code_q  <= code_d;
      errv_q  <= errv_d;
      errf_q  <= errf_d;
    end
  end

  assign op_valid  = opv_q;
  assign op_a      = a_q;
  assign op_b      = b_q;
  assign op_code   = code_q;
  assign err_valid = errv_q;
  assign err_flags = errf_q;

endmodule

// File: tb/tb_mtm_alu_rx_ctl.sv
// Scoreboard bench for mtm_alu_rx_ctl: packet-level driver, byte-list
// reference model, monitor comparing every output cycle to the queues.
module tb_mtm_alu_rx_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  op_code;
  logic        err_valid;
  logic [2:0]  err_flags;

  always #5 clk = ~clk;

  mtm_alu_rx_ctl dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_code   (op_code),
    .err_valid (err_valid),
    .err_flags (err_flags)
  );

`ifdef MTM_ALU_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
  } eop_t;

  eop_t       oq[$];
  logic [2:0] eq[$];
  logic [7:0] dq[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // remainder of message*x^4 divided by x^4+x+1
  function automatic logic [3:0] crc_ref(input logic [67:0] d);
    logic [71:0] r;
    r = {d, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic bit op_ok(input logic [2:0] op);
    return op inside {3'b000, 3'b001, 3'b100, 3'b101};
  endfunction

  task automatic model_ctl(input logic [7:0] c, input bit busy);
    logic [31:0] a, b;
    logic [2:0]  op;
    bit          derr, cerr;
    eop_t        o;
    op   = c[6:4];
    derr = (dq.size() != 8);
    a    = '0;
    b    = '0;
    if (!derr) begin
      b = {dq[0], dq[1], dq[2], dq[3]};
      a = {dq[4], dq[5], dq[6], dq[7]};
    end
    cerr = CRC_EN && !derr && (crc_ref({b, a, 1'b1, op}) != c[3:0]);
    if (derr)            eq.push_back(3'b100);
    else if (cerr)       eq.push_back(3'b010);
    else if (!op_ok(op)) eq.push_back(3'b001);
    else if (busy)       eq.push_back(3'b100);
    else begin
      o.a = a;
      o.b = b;
      o.c = op;
      oq.push_back(o);
    end
    dq.delete();
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic send_pkt(input logic flag, input logic [7:0] d,
                          input logic stop, input bit busy,
                          input bit rdy_stop);
    send_bit(1'b0);
    send_bit(flag);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
    if (rdy_stop) op_ready = 1'b1;
    if (!stop) begin
      eq.push_back(3'b100);
      dq.delete();
      send_bit(1'b1);
    end else if (!flag) dq.push_back(d);
    else model_ctl(d, busy);
    repeat ($urandom_range(0, 2)) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input int nd,
                            input bit crc_flip, input bit busy,
                            input bit rdy_stop, input bit rmode,
                            input int fe_idx);
    logic [63:0] w;
    logic [7:0]  c;
    w = {b, a};
    for (int i = 0; i < nd; i++) begin
      if (rmode) op_ready = 1'($urandom_range(0, 1));
      send_pkt(1'b0, w[63 - 8 * (i % 8) -: 8], i != fe_idx, 1'b0, 1'b0);
    end
    if (rmode) op_ready = 1'b1;
    c = {1'b0, op, crc_ref({b, a, 1'b1, op}) ^ {3'b000, crc_flip}};
    send_pkt(1'b1, c, 1'b1, busy, rdy_stop);
  endtask

  task automatic check_reset();
    chk(op_valid == 1'b0,  "rst_op_valid",  96'(op_valid),  96'(0));
    chk(err_valid == 1'b0, "rst_err_valid", 96'(err_valid), 96'(0));
    chk(err_flags == 3'b0, "rst_err_flags", 96'(err_flags), 96'(0));
    chk(op_a == 32'b0,     "rst_op_a",      96'(op_a),      96'(0));
    chk(op_b == 32'b0,     "rst_op_b",      96'(op_b),      96'(0));
    chk(op_code == 3'b0,   "rst_op_code",   96'(op_code),   96'(0));
  endtask

  // monitor
  initial begin
    eop_t o;
    logic [2:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (err_valid) begin
          chk(eq.size() != 0, "err_spurious", 96'(err_flags), 96'(0));
          if (eq.size() != 0) begin
            e = eq.pop_front();
            chk(err_flags == e, "err_flags", 96'(err_flags), 96'(e));
          end
        end
        if (op_valid) begin
          chk(oq.size() != 0, "op_spurious", 96'(op_code), 96'(0));
          if (oq.size() != 0) begin
            o = oq[0];
            chk({op_a, op_b, op_code} == o, "op",
                96'({op_a, op_b, op_code}), 96'(o));
            if (op_ready) void'(oq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    int          kind, nd, fe;
    bit          flip;
    logic [2:0]  good_ops[4];
    logic [2:0]  bad_ops[4];
    good_ops = '{3'b000, 3'b001, 3'b100, 3'b101};
    bad_ops  = '{3'b010, 3'b011, 3'b110, 3'b111};

    rst      = 1'b1;
    sin      = 1'b1;
    op_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_reset();
    @(negedge clk);
    rst      = 1'b0;
    op_ready = 1'b1;
    repeat (3) send_bit(1'b1);

    // B=0, A=all ones, ADD
    send_frame(32'hFFFF_FFFF, 32'h0, 3'b100, 8, 0, 0, 0, 0, -1);
    repeat (4) send_bit(1'b1);

    // short frame, then a good one
    send_frame(32'h1234_5678, 32'h9ABC_DEF0, 3'b001, 7, 0, 0, 0, 0, -1);
    send_frame(32'hCAFE_F00D, 32'h0BAD_BEEF, 3'b101, 8, 0, 0, 0, 0, -1);
    repeat (4) send_bit(1'b1);

    // corrupted CRC
    send_frame(32'h0000_FFFF, 32'h0000_FFFF, 3'b000, 8, 1, 0, 0, 0, -1);
    // illegal op, then illegal op with bad count
    send_frame(32'h5555_AAAA, 32'h0F0F_0F0F, 3'b111, 8, 0, 0, 0, 0, -1);
    send_frame(32'h5555_AAAA, 32'h0F0F_0F0F, 3'b111, 9, 0, 0, 0, 0, -1);
    // framing error inside a frame
    send_frame(32'h1111_2222, 32'h3333_4444, 3'b100, 8, 0, 0, 0, 0, 3);
    repeat (4) send_bit(1'b1);

    // long stall: second command dropped, first held
    op_ready = 1'b0;
    send_frame(32'hA5A5_A5A5, 32'h5A5A_5A5A, 3'b100, 8, 0, 0, 0, 0, -1);
    send_frame(32'h0102_0304, 32'h0506_0708, 3'b001, 8, 0, 1, 0, 0, -1);
    repeat (40) send_bit(1'b1);
    op_ready = 1'b1;
    repeat (4) send_bit(1'b1);

    // new command completes on the accept cycle of the old one
    op_ready = 1'b0;
    send_frame(32'hDEAD_0001, 32'hBEEF_0002, 3'b000, 8, 0, 0, 0, 0, -1);
    send_frame(32'hDEAD_0003, 32'hBEEF_0004, 3'b101, 8, 0, 0, 1, 0, -1);
    repeat (4) send_bit(1'b1);

    // abort with a pending command and a half-received DATA packet
    op_ready = 1'b0;
    send_frame(32'h7777_7777, 32'h8888_8888, 3'b100, 8, 0, 0, 0, 0, -1);
    send_bit(1'b0);
    send_bit(1'b0);
    repeat (3) send_bit(1'($urandom_range(0, 1)));
    @(negedge clk);
    rst = 1'b1;
    sin = 1'b1;
    oq.delete();
    eq.delete();
    dq.delete();
    repeat (2) @(negedge clk);
    #2;
    check_reset();
    @(negedge clk);
    rst      = 1'b0;
    op_ready = 1'b1;
    repeat (5) send_bit(1'b1);

    for (int f = 0; f < 150; f++) begin
      ra   = $urandom();
      rb   = $urandom();
      rop  = good_ops[$urandom_range(0, 3)];
      nd   = 8;
      flip = 1'b0;
      fe   = -1;
      kind = $urandom_range(0, 9);
      if (kind == 0)      nd = $urandom_range(0, 1) ? 9 : 7;
      else if (kind == 1) flip = 1'b1;
      else if (kind == 2) rop = bad_ops[$urandom_range(0, 3)];
      else if (kind == 3) fe = $urandom_range(0, 7);
      send_frame(ra, rb, rop, nd, flip, 0, 0, 1, fe);
    end

    op_ready = 1'b1;
    for (int i = 0; i < 300 && (oq.size() != 0 || eq.size() != 0); i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    chk(oq.size() == 0 && eq.size() == 0, "drain",
        96'(oq.size() + eq.size()), 96'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
